// File: rtl/interrupt_sequencer_pkg.sv
// bwzz_pkg: shared types and defaults for the interrupt entry sequencer
package bwzz_pkg;
  localparam int PC_W_DEF = 32;
  localparam int DATA_W_DEF = 16;
  localparam int FLAG_W = 4;
  localparam logic [31:0] VECTOR_ADDR_DEF = 32'h0000_0001;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_SAFE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    VECTOR,
    SERVICE
  } irq_state_t;
endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: stack push port between the sequencer (master) and the memory stage (slave)
interface interrupt_sequencer_if #(parameter int DATA_W = bwzz_pkg::DATA_W_DEF);
  logic pushValid;
  logic [DATA_W-1:0] pushData;
  logic pushReady;
  modport master(output pushValid, output pushData, input pushReady);
  modport slave(input pushValid, input pushData, output pushReady);
endinterface

// File: rtl/interrupt_sequencer_irq_edge_latch.sv
// irq_edge_latch: synchronises the interrupt pin, detects rising edges and holds a pending flag
//   interrupt in  raw level request
//   clear     in  drops pending (a same-cycle edge still wins)
//   pending   out latched request
//   rise      out one-cycle synchronised rising edge
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic interrupt,
  input  logic clear,
  output logic pending,
  output logic rise
);
  logic syncQ, prevQ;
  assign rise = syncQ & ~prevQ;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncQ <= 1'b0;
      prevQ <= 1'b0;
      pending <= 1'b0;
    end else begin
      syncQ <= interrupt;
      prevQ <= syncQ;
      pending <= rise | (pending & ~clear);
    end
  end
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: drains the pipeline, pushes the resume PC and redirects fetch on an interrupt
//   interrupt/flush/twoWordPending/rtiRetired  pipeline status inputs
//   pcResume, ccr                              state captured at the end of the drain
//   stackPort (master)                         two-word push of the resume PC, high word first
//   stallFetch, injectBubble                   held from DRAIN through VECTOR
//   savedFlags/saveFlags, vectorLoad/vectorAddr, inService
module interrupt_sequencer
  import bwzz_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0] VECTOR_ADDR = VECTOR_ADDR_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic interrupt,
  input  logic flush,
  input  logic twoWordPending,
  input  logic rtiRetired,
  input  logic [PC_W-1:0] pcResume,
  input  logic [FLAG_W-1:0] ccr,
  interrupt_sequencer_if.master stackPort,
  output logic stallFetch,
  output logic injectBubble,
  output logic [FLAG_W-1:0] savedFlags,
  output logic saveFlags,
  output logic vectorLoad,
  output logic [PC_W-1:0] vectorAddr,
  output logic inService
);
  localparam logic [3:0] drainLoad = 4'(DRAIN_CYCLES - 1);
  irq_state_t state, stateNext;
  logic [3:0] drainCnt;
  logic [PC_W-1:0] pcHold;
  logic pending, rise, pushValid;
  logic [DATA_W-1:0] pushData;
  irq_edge_latch uLatch (
    .clk(clk),
    .reset(reset),
    .interrupt(interrupt),
    .clear(vectorLoad),
    .pending(pending),
    .rise(rise)
  );
  assign vectorAddr = VECTOR_ADDR;
  assign stackPort.pushValid = pushValid;
  assign stackPort.pushData = pushData;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= stateNext;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drainCnt <= 4'd0;
      pcHold <= '0;
      savedFlags <= '0;
      inService <= 1'b0;
    end else begin
      // a flush mid-drain means new instructions entered the pipe, so the drain restarts
      if (state == WAIT_SAFE || (state == DRAIN && flush)) drainCnt <= drainLoad;
      else if (state == DRAIN && drainCnt != 4'd0) drainCnt <= drainCnt - 4'd1;
      if (saveFlags) begin
        pcHold <= pcResume;
        savedFlags <= ccr;
      end
      if (vectorLoad) inService <= 1'b1;
      else if (state == SERVICE && rtiRetired) inService <= 1'b0;
    end
  end
  always_comb begin
    stateNext = state;
    stallFetch = 1'b0;
    injectBubble = 1'b0;
    saveFlags = 1'b0;
    vectorLoad = 1'b0;
    pushValid = 1'b0;
    pushData = '0;
    case (state)
      IDLE: stateNext = pending ? WAIT_SAFE : IDLE;
      WAIT_SAFE: stateNext = (!flush && !twoWordPending) ? DRAIN : WAIT_SAFE;
      DRAIN: begin
        stallFetch = 1'b1;
        injectBubble = 1'b1;
        saveFlags = drainCnt == 4'd0 && !flush;
        stateNext = saveFlags ? PUSH_HI : DRAIN;
      end
      PUSH_HI: begin
        stallFetch = 1'b1;
        injectBubble = 1'b1;
        pushValid = 1'b1;
        pushData = pcHold[PC_W-1 -: DATA_W];
        stateNext = stackPort.pushReady ? PUSH_LO : PUSH_HI;
      end
      PUSH_LO: begin
        stallFetch = 1'b1;
        injectBubble = 1'b1;
        pushValid = 1'b1;
        pushData = pcHold[DATA_W-1:0];
        stateNext = stackPort.pushReady ? VECTOR : PUSH_LO;
      end
      VECTOR: begin
        stallFetch = 1'b1;
        injectBubble = 1'b1;
        vectorLoad = 1'b1;
        stateNext = SERVICE;
      end
      // an edge coincident with rtiRetired has not reached pending yet, so look at rise too
      SERVICE: stateNext = rtiRetired ? ((pending || rise) ? WAIT_SAFE : IDLE) : SERVICE;
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed cycle-by-cycle vectors plus reset-abort sequence
module tb_interrupt_sequencer;
  import bwzz_pkg::*;
  typedef struct {
    logic intr, flush, tw, rdy, rti;
    logic [31:0] pc;
    logic [3:0] ccr;
    logic st, pv;
    logic [15:0] pd;
    logic sf, vl, ins;
    logic [3:0] flg;
  } vec_t;
  localparam int NV = 51;
  localparam logic [31:0] PC0 = 32'h0001_2345;
  localparam logic [31:0] PC1 = 32'h0000_0040;
  localparam logic [3:0] FA = 4'b1010, FB = 4'b0101, FC = 4'b0011;
  logic clk = 1'b0, reset = 1'b1;
  logic interrupt = 1'b0, flush = 1'b0, twoWordPending = 1'b0, rtiRetired = 1'b0;
  logic [31:0] pcResume = '0;
  logic [3:0] ccr = '0;
  logic stallFetch, injectBubble, saveFlags, vectorLoad, inService;
  logic [3:0] savedFlags;
  logic [31:0] vectorAddr;
  int tests = 0, fails = 0;
  vec_t vecs[NV];
  interrupt_sequencer_if #(.DATA_W(16)) stackBus ();
  interrupt_sequencer dut (
    .clk(clk),
    .reset(reset),
    .interrupt(interrupt),
    .flush(flush),
    .twoWordPending(twoWordPending),
    .rtiRetired(rtiRetired),
    .pcResume(pcResume),
    .ccr(ccr),
    .stackPort(stackBus),
    .stallFetch(stallFetch),
    .injectBubble(injectBubble),
    .savedFlags(savedFlags),
    .saveFlags(saveFlags),
    .vectorLoad(vectorLoad),
    .vectorAddr(vectorAddr),
    .inService(inService)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic intr, logic fl, logic tw, logic rdy, logic rti, logic [31:0] pc,
                              logic [3:0] cc, logic st, logic pv, logic [15:0] pd, logic sf,
                              logic vl, logic ins, logic [3:0] flg);
    vec_t v;
    v.intr = intr; v.flush = fl; v.tw = tw; v.rdy = rdy; v.rti = rti; v.pc = pc; v.ccr = cc;
    v.st = st; v.pv = pv; v.pd = pd; v.sf = sf; v.vl = vl; v.ins = ins; v.flg = flg;
    return v;
  endfunction
  function automatic logic [28:0] outs();
    return {stallFetch, injectBubble, stackBus.pushValid, stackBus.pushData, saveFlags, vectorLoad,
            inService, savedFlags};
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    // basic entry: DRAIN_CYCLES=3, pushReady=1
    vecs[0] = mk(1,0,0,1,0,PC0,FA, 0,0,16'h0,0,0,0,4'h0);
    vecs[1] = vecs[0];
    vecs[2] = vecs[0];
    vecs[3] = vecs[0];
    vecs[4] = mk(1,0,0,1,0,PC0,FA, 1,0,16'h0,0,0,0,4'h0);
    vecs[5] = vecs[4];
    vecs[6] = mk(1,0,0,1,0,PC0,FA, 1,0,16'h0,1,0,0,4'h0);
    vecs[7] = mk(1,0,0,1,0,PC0,FA, 1,1,16'h0001,0,0,0,FA);
    vecs[8] = mk(1,0,0,1,0,PC0,FA, 1,1,16'h2345,0,0,0,FA);
    vecs[9] = mk(1,0,0,1,0,PC0,FA, 1,0,16'h0,0,1,0,FA);
    vecs[10] = mk(1,0,0,1,0,PC0,FA, 0,0,16'h0,0,0,1,FA);
    vecs[11] = mk(0,0,0,1,1,PC0,FA, 0,0,16'h0,0,0,1,FA);
    vecs[12] = mk(0,0,0,1,0,PC0,FA, 0,0,16'h0,0,0,0,FA);
    vecs[13] = mk(0,0,0,1,1,PC0,FA, 0,0,16'h0,0,0,0,FA);
    // unsafe boundary for 4 cycles, then backpressure in PUSH_HI
    vecs[14] = mk(1,0,0,1,0,PC0,FB, 0,0,16'h0,0,0,0,FA);
    vecs[15] = vecs[14];
    vecs[16] = vecs[14];
    for (int i = 17; i <= 20; i++) vecs[i] = mk(1,0,1,1,0,PC0,FB, 0,0,16'h0,0,0,0,FA);
    vecs[21] = vecs[14];
    vecs[22] = mk(1,0,0,1,0,PC0,FB, 1,0,16'h0,0,0,0,FA);
    vecs[23] = mk(1,0,0,1,1,PC0,FB, 1,0,16'h0,0,0,0,FA);
    vecs[24] = mk(1,0,0,1,0,PC0,FB, 1,0,16'h0,1,0,0,FA);
    for (int i = 25; i <= 27; i++) vecs[i] = mk(1,0,0,0,0,PC0,FB, 1,1,16'h0001,0,0,0,FB);
    vecs[28] = mk(0,0,0,1,0,PC0,FB, 1,1,16'h0001,0,0,0,FB);
    vecs[29] = mk(0,0,0,1,0,PC0,FB, 1,1,16'h2345,0,0,0,FB);
    vecs[30] = mk(0,0,0,1,0,PC0,FB, 1,0,16'h0,0,1,0,FB);
    // second edge in SERVICE, then rtiRetired restarts without another edge
    vecs[31] = mk(1,0,0,1,0,PC0,FB, 0,0,16'h0,0,0,1,FB);
    vecs[32] = vecs[31];
    vecs[33] = mk(1,0,0,1,1,PC0,FB, 0,0,16'h0,0,0,1,FB);
    vecs[34] = mk(1,0,0,1,0,PC0,FC, 0,0,16'h0,0,0,0,FB);
    // flush on the second drain cycle restarts the drain with a new resume PC
    vecs[35] = mk(1,0,0,1,0,PC0,FC, 1,0,16'h0,0,0,0,FB);
    vecs[36] = mk(1,1,0,1,0,PC1,FC, 1,0,16'h0,0,0,0,FB);
    vecs[37] = mk(1,0,0,1,0,PC1,FC, 1,0,16'h0,0,0,0,FB);
    vecs[38] = vecs[37];
    vecs[39] = mk(1,0,0,1,0,PC1,FC, 1,0,16'h0,1,0,0,FB);
    vecs[40] = mk(0,0,0,1,0,PC1,FC, 1,1,16'h0000,0,0,0,FC);
    vecs[41] = mk(0,0,0,1,0,PC1,FC, 1,1,16'h0040,0,0,0,FC);
    vecs[42] = mk(0,0,0,1,0,PC1,FC, 1,0,16'h0,0,1,0,FC);
    vecs[43] = mk(0,0,0,1,0,PC1,FC, 0,0,16'h0,0,0,1,FC);
    // edge and rtiRetired in the same cycle: straight to WAIT_SAFE
    vecs[44] = mk(1,0,0,1,0,PC1,FC, 0,0,16'h0,0,0,1,FC);
    vecs[45] = mk(1,0,0,1,1,PC1,FC, 0,0,16'h0,0,0,1,FC);
    vecs[46] = mk(1,0,0,1,0,PC1,FC, 0,0,16'h0,0,0,0,FC);
    vecs[47] = mk(1,0,0,1,0,PC1,FC, 1,0,16'h0,0,0,0,FC);
    vecs[48] = vecs[47];
    vecs[49] = mk(1,0,0,1,0,PC1,FC, 1,0,16'h0,1,0,0,FC);
    vecs[50] = mk(1,0,0,1,0,PC1,FC, 1,1,16'h0000,0,0,0,FC);
    stackBus.pushReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {3'b0, outs()}, 32'h0);
    check("vector_addr", vectorAddr, 32'h0000_0001);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      interrupt = vecs[i].intr;
      flush = vecs[i].flush;
      twoWordPending = vecs[i].tw;
      stackBus.pushReady = vecs[i].rdy;
      rtiRetired = vecs[i].rti;
      pcResume = vecs[i].pc;
      ccr = vecs[i].ccr;
      @(negedge clk);
      check($sformatf("row%0d", i), {3'b0, outs()},
            {3'b0, vecs[i].st, vecs[i].st, vecs[i].pv, vecs[i].pd, vecs[i].sf, vecs[i].vl,
             vecs[i].ins, vecs[i].flg});
    end
    @(posedge clk);
    #1;
    interrupt = 1'b0;
    @(negedge clk);
    check("push_lo_before_reset", {15'b0, stackBus.pushValid, stackBus.pushData}, {15'b0, 1'b1, 16'h0040});
    #2 reset = 1'b1;
    #1;
    check("reset_abort_outputs", {3'b0, outs()}, 32'h0);
    check("reset_abort_state", {29'b0, dut.state}, {29'b0, IDLE});
    check("reset_abort_pending", {31'b0, dut.uLatch.pending}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d", i), {30'b0, vectorLoad, stallFetch}, 32'h0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequences interrupt entry for the five-stage pipeline. It latches the external interrupt pin, waits for a safe boundary, freezes fetch and drains in-flight instructions with bubbles, pushes the 32-bit resume PC as two 16-bit stack words, snapshots the flags, and redirects fetch to the interrupt vector. It sits beside the hazard detection unit and drives the fetch stall/redirect, the ID/EX bubble insert and the memory-stage push port.

## Interface
Parameters:
- PC_W, 32, program counter width
- DATA_W, 16, data/stack word width
- DRAIN_CYCLES, 3, bubble cycles needed to empty ID/EX/MEM before the push (legal range 1..15)
- VECTOR_ADDR, 32'h0000_0001, fetch address loaded on entry

Ports (clock and reset first):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- interrupt  in  1  external request, level; a rising edge is a request
- flush  in  1  branch flush in EX this cycle
- twoWordPending  in  1  fetch holds the first word of a two-word instruction
- rtiRetired  in  1  one-cycle pulse when RTI completes write-back
- pcResume  in  PC_W  address of the oldest not-yet-executed instruction
- ccr  in  4  current status flags
- pushReady  in  1  memory stage accepts a push this cycle
- stallFetch  out  1  hold PC and IF/ID
- injectBubble  out  1  force a bubble into ID/EX
- pushValid  out  1  push request to the stack port
- pushData  out  DATA_W  word to push
- savedFlags  out  4  flags captured at entry
- saveFlags  out  1  one-cycle capture strobe
- vectorLoad  out  1  one-cycle fetch redirect strobe
- vectorAddr  out  PC_W  constant VECTOR_ADDR
- inService  out  1  handler active; set on the vectorLoad cycle, cleared by rtiRetired

## Operation
- Edge detect: a registered copy of interrupt; rising edge sets `pending`. Further edges while pending is set are absorbed.
- States: IDLE, WAIT_SAFE, DRAIN, PUSH_HI, PUSH_LO, VECTOR, SERVICE.
- IDLE: go to WAIT_SAFE when pending=1.
- WAIT_SAFE: go to DRAIN when flush=0 and twoWordPending=0; otherwise stay.
- DRAIN: stallFetch=1 and injectBubble=1. A 4-bit counter loads DRAIN_CYCLES-1 on entry and decrements each cycle. At 0, capture pcResume into `pcHold`, capture ccr into savedFlags, pulse saveFlags, and go to PUSH_HI. A flush while in DRAIN reloads the counter.
- PUSH_HI: pushValid=1, pushData=pcHold[31:16]. Advance to PUSH_LO on pushReady; hold otherwise.
- PUSH_LO: same with pcHold[15:0]. Advance to VECTOR on pushReady.
- VECTOR: vectorLoad=1. Clear pending, set inService, go to SERVICE.
- SERVICE: all controls low. On rtiRetired, clear inService and go to IDLE, or to WAIT_SAFE if pending=1.
- stallFetch and injectBubble stay 1 from DRAIN through VECTOR inclusive.
- Edges arriving in SERVICE set pending; there is no nesting.

## Timing
- Reset: state IDLE; pending, the edge register, counter, pcHold, savedFlags, pushData and every 1-bit output are 0. vectorAddr = VECTOR_ADDR always.
- Reset mid-sequence aborts immediately. Any partial push is abandoned; the stack pointer is the memory stage's concern.
- Rising edge of interrupt sampled at edge n: pending=1 after n+1, WAIT_SAFE after n+2 (if IDLE).
- Best-case latency from pending=1 to the vectorLoad cycle is 1 + DRAIN_CYCLES + 2 + 1 cycles, with pushReady held at 1.
- The push handshake completes on a cycle where pushValid and pushReady are both 1; pushData is stable while pushValid=1.
- rtiRetired and a new interrupt edge in the same cycle: both honoured (pending set, SERVICE exits to WAIT_SAFE next cycle).
- rtiRetired outside SERVICE is ignored.

## Structure
- Shared package `bwzz_pkg`: state enum `irq_state_t`, PC_W/DATA_W defaults, VECTOR_ADDR, flag-width constant (4).
- One natural sub-module, `irq_edge_latch`: synchroniser, rising-edge detect and pending flag, with a clear input.
- FSM, drain counter and push mux live in the top.
- Target size is about 200 RTL lines.

## Test plan
- Basic entry: DRAIN_CYCLES=3, pushReady=1, pcResume=32'h0001_2345, ccr=4'b1010. Response: pushes 16'h0001 then 16'h2345, savedFlags=4'b1010, vectorLoad 7 cycles after pending, inService=1.
- Unsafe boundary: twoWordPending=1 for 4 cycles after the request. Response: stays in WAIT_SAFE, stallFetch=0 throughout, then proceeds; latency grows by 4.
- Backpressure: pushReady=0 for 3 cycles during PUSH_HI. Response: pushData holds 16'h0001 and pushValid=1, no advance until pushReady=1.
- Flush during DRAIN: flush pulses on the second drain cycle with pcResume changing to 32'h0000_0040. Response: counter restarts, and the pushed words are 16'h0000 and 16'h0040.
- Pending during service: a second edge arrives in SERVICE, then rtiRetired. Response: inService drops, and the next sequence starts with no extra edge.
- Asynchronous reset asserted in PUSH_LO. Response: all outputs 0 immediately, state IDLE, pending=0, no vectorLoad afterwards.
